// File: rtl/demux_scan_n.sv
// demux_scan_n: registered 1-to-N demultiplexer with an auto-scan mode for
// time-multiplexed display drivers (e.g. 7-segment digit strobing).
//
// Direct mode routes i_in to channel i_sel with a one-cycle strobe. Scan mode
// steps a pointer across the channels every SCAN_DIV cycles. The channel under
// the pointer tracks its slice of i_scan_data live.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_mode       0 = direct, 1 = scan
//   i_hold       1 = inactive channels keep their value, 0 = they load IDLE_VAL
//   i_valid      direct-mode write qualifier
//   i_sel        direct-mode target channel
//   i_in         direct-mode data word
//   i_scan_data  scan-mode data, channel k at [k*WIDTH +: WIDTH]
//   o_data       registered channel outputs, same packing as i_scan_data
//   o_strobe     one-hot pulse on a channel load (direct) or scan step (scan)
//   o_active_ch  current channel
//   o_err        sticky: out-of-range direct select seen
module demux_scan_n #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      CHANNELS = 4,
  parameter int unsigned      SEL_W    = 2,
  parameter int unsigned      SCAN_DIV = 50000,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_mode,
  input  logic                      i_hold,
  input  logic                      i_valid,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [WIDTH-1:0]          i_in,
  input  logic [CHANNELS*WIDTH-1:0] i_scan_data,
  output logic [CHANNELS*WIDTH-1:0] o_data,
  output logic [CHANNELS-1:0]       o_strobe,
  output logic [SEL_W-1:0]          o_active_ch,
  output logic                      o_err
);

  localparam int unsigned      PresW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] LastCh  = SEL_W'(CHANNELS - 1);

  logic [CHANNELS-1:0][WIDTH-1:0] data_q, data_d;
  logic [CHANNELS-1:0][WIDTH-1:0] scan_arr;
  logic [CHANNELS-1:0]            strobe_q, strobe_d;
  logic [SEL_W-1:0]               act_q, act_d;
  logic [SEL_W-1:0]               ptr_q, ptr_d;
  logic [PresW-1:0]               presc_q, presc_d;
  logic                           mode_q;
  logic                           err_q, err_d;

  logic                           mode_chg;
  logic                           tick;
  logic                           sel_ok;
  logic                           load_en;
  logic [SEL_W-1:0]               load_ch;
  logic [WIDTH-1:0]               load_val;
  logic                           strobe_en;
  logic [SEL_W-1:0]               strobe_idx;

  assign scan_arr = i_scan_data;

  always_comb begin
    presc_d    = presc_q;
    ptr_d      = ptr_q;
    act_d      = act_q;
    err_d      = err_q;
    load_en    = 1'b0;
    load_ch    = '0;
    load_val   = '0;
    strobe_en  = 1'b0;
    strobe_idx = '0;
    mode_chg   = (mode_q != i_mode);
    tick       = 1'b0;
    sel_ok     = (32'(i_sel) < CHANNELS);

    if (mode_chg) begin
      // Restart the scan sequence; no strobe and no direct write on this edge.
      presc_d = '0;
      ptr_d   = '0;
      if (i_mode) begin
        act_d    = '0;
        load_en  = 1'b1;
        load_ch  = '0;
        load_val = scan_arr[0];
      end
    end else if (mode_q) begin
      tick = (presc_q == PresMax);
      if (tick) begin
        presc_d    = '0;
        ptr_d      = (ptr_q == LastCh) ? '0 : ptr_q + 1'b1;
        strobe_en  = 1'b1;
        strobe_idx = ptr_d;
      end else begin
        presc_d = presc_q + 1'b1;
      end
      // Active channel follows its scan slice every cycle.
      act_d    = ptr_d;
      load_en  = 1'b1;
      load_ch  = ptr_d;
      load_val = scan_arr[ptr_d];
    end else if (i_valid) begin
      if (sel_ok) begin
        act_d      = i_sel;
        load_en    = 1'b1;
        load_ch    = i_sel;
        load_val   = i_in;
        strobe_en  = 1'b1;
        strobe_idx = i_sel;
      end else begin
        err_d = 1'b1;
      end
    end

    for (int unsigned k = 0; k < CHANNELS; k++) begin
      strobe_d[k] = strobe_en && (strobe_idx == SEL_W'(k));
      if (load_en && (load_ch == SEL_W'(k))) begin
        data_d[k] = load_val;
      end else if (i_hold) begin
        data_d[k] = data_q[k];
      end else begin
        data_d[k] = IDLE_VAL;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q   <= {CHANNELS{IDLE_VAL}};
      strobe_q <= '0;
      act_q    <= '0;
      ptr_q    <= '0;
      presc_q  <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      strobe_q <= strobe_d;
      act_q    <= act_d;
      ptr_q    <= ptr_d;
      presc_q  <= presc_d;
      mode_q   <= i_mode;
      err_q    <= err_d;
    end
  end

  assign o_data      = data_q;
  assign o_strobe    = strobe_q;
  assign o_active_ch = act_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_demux_scan_n.sv
// Bench for demux_scan_n: three configurations share one stimulus stream.
//   u_a: 4 channels, SCAN_DIV 4, idle 00
//   u_b: 3 channels, SCAN_DIV 2, idle EE (exercises out-of-range select)
//   u_c: 4 channels, SCAN_DIV 1, idle 5A
// Expected responses are computed from elapsed-cycle arithmetic and queued;
// a monitor pops and compares on the falling clock edge.
module tb_demux_scan_n;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  stb;
    logic [1:0]  act;
    logic        err;
  } exp_t;

  typedef struct {
    string       nm;
    int          fld;
    logic [31:0] val;
  } lit_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_mode, i_hold, i_valid;
  logic [1:0]  i_sel;
  logic [7:0]  i_in;
  logic [31:0] i_scan_data;

  logic [31:0] a_data;
  logic [3:0]  a_stb;
  logic [1:0]  a_act;
  logic        a_err;
  logic [23:0] b_data;
  logic [2:0]  b_stb;
  logic [1:0]  b_act;
  logic        b_err;
  logic [31:0] c_data;
  logic [3:0]  c_stb;
  logic [1:0]  c_act;
  logic        c_err;

  demux_scan_n #(
    .WIDTH(8), .CHANNELS(4), .SEL_W(2), .SCAN_DIV(4), .IDLE_VAL(8'h00)
  ) u_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_hold(i_hold),
    .i_valid(i_valid), .i_sel(i_sel), .i_in(i_in), .i_scan_data(i_scan_data),
    .o_data(a_data), .o_strobe(a_stb), .o_active_ch(a_act), .o_err(a_err)
  );

  demux_scan_n #(
    .WIDTH(8), .CHANNELS(3), .SEL_W(2), .SCAN_DIV(2), .IDLE_VAL(8'hEE)
  ) u_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_hold(i_hold),
    .i_valid(i_valid), .i_sel(i_sel), .i_in(i_in), .i_scan_data(i_scan_data[23:0]),
    .o_data(b_data), .o_strobe(b_stb), .o_active_ch(b_act), .o_err(b_err)
  );

  demux_scan_n #(
    .WIDTH(8), .CHANNELS(4), .SEL_W(2), .SCAN_DIV(1), .IDLE_VAL(8'h5A)
  ) u_c (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_hold(i_hold),
    .i_valid(i_valid), .i_sel(i_sel), .i_in(i_in), .i_scan_data(i_scan_data),
    .o_data(c_data), .o_strobe(c_stb), .o_active_ch(c_act), .o_err(c_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  int         cfg_ch  [3] = '{4, 3, 4};
  int         cfg_div [3] = '{4, 2, 1};
  logic [7:0] cfg_idle[3] = '{8'h00, 8'hEE, 8'h5A};

  logic       m_mode[3];
  int         m_cnt [3];   // cycles since the edge that entered the current mode
  logic [7:0] m_data[3][4];
  logic [1:0] m_act [3];
  logic       m_err [3];

  exp_t q_a[$], q_b[$], q_c[$];
  lit_t lit_q[$], lit_pend[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void model_step(int d);
    exp_t       e;
    int         ld;
    int         p;
    logic [7:0] ldv;
    logic [3:0] stb;
    ld  = -1;
    ldv = '0;
    stb = '0;
    if (!i_rst_n) begin
      m_mode[d] = 1'b0;
      m_cnt[d]  = 0;
      m_act[d]  = '0;
      m_err[d]  = 1'b0;
      for (int k = 0; k < 4; k++) m_data[d][k] = cfg_idle[d];
    end else begin
      if (m_mode[d] != i_mode) begin
        m_cnt[d] = 0;
        if (i_mode) begin
          m_act[d] = '0;
          ld       = 0;
          ldv      = i_scan_data[7:0];
        end
      end else if (m_mode[d]) begin
        m_cnt[d] = m_cnt[d] + 1;
        p = (m_cnt[d] / cfg_div[d]) % cfg_ch[d];
        if ((m_cnt[d] % cfg_div[d]) == 0) stb[p] = 1'b1;
        m_act[d] = 2'(p);
        ld       = p;
        ldv      = i_scan_data[p*8 +: 8];
      end else if (i_valid) begin
        if (int'(i_sel) < cfg_ch[d]) begin
          ld         = int'(i_sel);
          ldv        = i_in;
          m_act[d]   = i_sel;
          stb[i_sel] = 1'b1;
        end else begin
          m_err[d] = 1'b1;
        end
      end
      for (int k = 0; k < cfg_ch[d]; k++) begin
        if (k == ld) m_data[d][k] = ldv;
        else if (!i_hold) m_data[d][k] = cfg_idle[d];
      end
      m_mode[d] = i_mode;
    end
    e.data = '0;
    for (int k = 0; k < cfg_ch[d]; k++) e.data[k*8 +: 8] = m_data[d][k];
    e.stb = stb;
    e.act = m_act[d];
    e.err = m_err[d];
    case (d)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endfunction

  function automatic exp_t reset_exp(int d);
    exp_t e;
    e = '0;
    for (int k = 0; k < cfg_ch[d]; k++) e.data[k*8 +: 8] = cfg_idle[d];
    return e;
  endfunction

  // ---------------- monitor ----------------
  function automatic exp_t dut_out(int d);
    exp_t r;
    case (d)
      0: begin
        r.data = a_data; r.stb = a_stb; r.act = a_act; r.err = a_err;
      end
      1: begin
        r.data = {8'h00, b_data}; r.stb = {1'b0, b_stb}; r.act = b_act; r.err = b_err;
      end
      default: begin
        r.data = c_data; r.stb = c_stb; r.act = c_act; r.err = c_err;
      end
    endcase
    return r;
  endfunction

  function automatic void check_exp(string nm, int d, exp_t e);
    exp_t g;
    g = dut_out(d);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got data=%h stb=%b act=%0d err=%b, expected data=%h stb=%b act=%0d err=%b",
               nm, d, $time, g.data, g.stb, g.act, g.err, e.data, e.stb, e.act, e.err);
    end
  endfunction

  function automatic logic [31:0] lit_field(int f);
    case (f)
      0:       return a_data;
      1:       return {28'h0, a_stb};
      2:       return {31'h0, b_err};
      default: return {30'h0, c_act};
    endcase
  endfunction

  logic rst_prev = 1'b1;

  always begin
    exp_t e;
    lit_t l;
    logic [31:0] got;
    @(negedge i_clk or negedge i_rst_n);
    if (rst_prev && !i_rst_n) begin
      // Reset asserted between edges: outputs must clear without a clock.
      rst_prev = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) check_exp("async_reset", d, reset_exp(d));
    end else begin
      rst_prev = i_rst_n;
      while (q_a.size() > 0) begin e = q_a.pop_front(); check_exp("sb", 0, e); end
      while (q_b.size() > 0) begin e = q_b.pop_front(); check_exp("sb", 1, e); end
      while (q_c.size() > 0) begin e = q_c.pop_front(); check_exp("sb", 2, e); end
      while (lit_q.size() > 0) begin
        l   = lit_q.pop_front();
        got = lit_field(l.fld);
        n_tests++;
        if (got !== l.val) begin
          n_fail++;
          $display("FAIL %s @%0t: got %h, expected %h", l.nm, $time, got, l.val);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic lit(input string nm, input int fld, input logic [31:0] val);
    lit_t l;
    l.nm  = nm;
    l.fld = fld;
    l.val = val;
    lit_pend.push_back(l);
  endtask

  // One clock: model samples the inputs at the rising edge, then return at the
  // falling edge so the caller can change inputs away from the active edge.
  task automatic cyc();
    @(posedge i_clk);
    for (int d = 0; d < 3; d++) model_step(d);
    while (lit_pend.size() > 0) lit_q.push_back(lit_pend.pop_front());
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    #2;
    i_rst_n = 1'b0;
    cyc();
    cyc();
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_mode      = 1'b0;
    i_hold      = 1'b0;
    i_valid     = 1'b0;
    i_sel       = '0;
    i_in        = '0;
    i_scan_data = '0;
    #1;
    i_rst_n = 1'b0;
    lit("reset_data", 0, 32'h0);
    cyc();
    cyc();
    cyc();
    i_rst_n = 1'b1;

    // Direct writes, inactive channels idle.
    i_valid = 1'b1; i_sel = 2'd2; i_in = 8'hA5;
    lit("dir_w2_data", 0, 32'h00A5_0000);
    lit("dir_w2_stb", 1, 32'h4);
    cyc();
    i_sel = 2'd0; i_in = 8'h3C;
    lit("dir_w0_data", 0, 32'h0000_003C);
    lit("dir_w0_stb", 1, 32'h1);
    cyc();

    // Same writes with hold.
    i_hold = 1'b1; i_sel = 2'd2; i_in = 8'hA5;
    cyc();
    i_sel = 2'd0; i_in = 8'h3C;
    lit("hold_data", 0, 32'h00A5_003C);
    cyc();
    i_valid = 1'b0;
    lit("hold_novalid_data", 0, 32'h00A5_003C);
    lit("hold_novalid_stb", 1, 32'h0);
    cyc();

    // Out-of-range select on the 3-channel instance; sticky until reset.
    i_valid = 1'b1; i_sel = 2'd3; i_in = 8'h99;
    lit("err_set", 2, 32'h1);
    cyc();
    i_sel = 2'd1; i_in = 8'h77;
    lit("err_sticky", 2, 32'h1);
    cyc();
    i_valid = 1'b0;
    do_reset();
    lit("err_cleared", 2, 32'h0);
    cyc();

    // Scan mode, SCAN_DIV 4 on u_a, SCAN_DIV 1 on u_c.
    i_hold = 1'b0; i_mode = 1'b1; i_scan_data = 32'h4433_2211;
    lit("scan_enter_data", 0, 32'h0000_0011);
    lit("scan_enter_stb", 1, 32'h0);
    lit("div1_act0", 3, 32'd0);
    cyc();
    lit("div1_act1", 3, 32'd1);
    cyc();
    lit("div1_act2", 3, 32'd2);
    cyc();
    lit("scan_pre_tick_stb", 1, 32'h0);
    lit("scan_pre_tick_data", 0, 32'h0000_0011);
    cyc();
    lit("scan_tick1_data", 0, 32'h0000_2200);
    lit("scan_tick1_stb", 1, 32'h2);
    cyc();
    i_scan_data = 32'h4433_AA11;
    lit("scan_live_data", 0, 32'h0000_AA00);
    cyc();
    repeat (10) cyc();
    lit("scan_wrap_data", 0, 32'h0000_0011);
    lit("scan_wrap_stb", 1, 32'h1);
    cyc();
    cyc();

    // Leave scan mid-count, then re-enter: first tick four cycles later.
    i_mode = 1'b0;
    cyc();
    i_mode = 1'b1;
    lit("reenter_stb", 1, 32'h0);
    cyc();
    repeat (3) cyc();
    lit("reenter_tick_stb", 1, 32'h2);
    cyc();

    // Randomized traffic.
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 39) == 0) i_mode = ~i_mode;
      i_hold  = 1'($urandom_range(0, 1));
      i_valid = ($urandom_range(0, 2) != 0);
      i_sel   = 2'($urandom_range(0, 3));
      i_in    = 8'($urandom);
      if ($urandom_range(0, 3) == 0) i_scan_data = $urandom;
      if ($urandom_range(0, 199) == 0) do_reset();
      cyc();
    end

    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
